// File: rtl/loop_counter_pkg.sv
// loop_counter_pkg: shared state encoding, level limit and packed-slice helper for loop_counter.
package loop_counter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int MAX_LEVELS = 4;

    function automatic int slice_off(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/loop_counter_count_level.sv
// count_level: one nested-loop index register with explicit wrap at its latched limit.
module count_level #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             carry_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_limit_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] count_q;

    assign count_o    = count_q;
    assign at_limit_o = (count_q == limit_i);
    assign carry_o    = carry_i & at_limit_o;

    // Wrap is taken on the limit compare so a full-range limit never relies on overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         count_q <= '0;
        else if (clr_i)   count_q <= '0;
        else if (carry_i) count_q <= at_limit_o ? '0 : count_q + WIDTH'(1);
    end

endmodule

// File: rtl/loop_counter.sv
// loop_counter: nested multi-level index sequencer with start/clear, stall, wrap and done pulses.
module loop_counter
    import loop_counter_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int LEVELS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    continuous,
    input  logic [LEVELS*WIDTH-1:0] limit,
    output logic [LEVELS*WIDTH-1:0] count,
    output logic                    valid,
    output logic                    busy,
    output logic [LEVELS-1:0]       level_wrap,
    output logic                    done
);

    state_e                  state_q;
    logic [LEVELS*WIDTH-1:0] limit_q;
    logic                    cont_q, done_q, done_d;
    logic [LEVELS-1:0]       wrap_q, wrap_d, at_limit;
    logic [LEVELS:0]         carry;
    logic                    consume, terminal, launch, clr;

    assign launch   = start & ~clear & (state_q != RUN);
    assign consume  = (state_q == RUN) & enable & ~clear;
    assign terminal = &at_limit;
    assign clr      = clear | launch;
    // A one-shot terminal consume must not advance, so DONE keeps showing the last tuple.
    assign carry[0] = consume & ~(terminal & ~cont_q);
    assign done_d   = consume & terminal;
    assign wrap_d   = done_d ? '1 : carry[LEVELS:1];

    genvar i;
    generate
        for (i = 0; i < LEVELS; i++) begin : g_lvl
            count_level #(.WIDTH(WIDTH)) u_lvl (
                .clk        (clk),
                .rst        (rst),
                .limit_i    (limit_q[slice_off(i, WIDTH) +: WIDTH]),
                .carry_i    (carry[i]),
                .clr_i      (clr),
                .count_o    (count[slice_off(i, WIDTH) +: WIDTH]),
                .at_limit_o (at_limit[i]),
                .carry_o    (carry[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            limit_q <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= '0;
        end else begin
            done_q <= done_d;
            wrap_q <= wrap_d;
            if (clear) begin
                state_q <= IDLE;
            end else if (launch) begin
                state_q <= RUN;
                limit_q <= limit;
                cont_q  <= continuous;
            end else if (done_d && !cont_q) begin
                state_q <= DONE;
            end
        end
    end

    assign valid      = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign level_wrap = wrap_q;

endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: vector table plus scoreboard queue checking loop_counter with WIDTH=12, LEVELS=2.
module tb_loop_counter;

    logic        clk = 1'b0;
    logic        rst, start, clear, enable, continuous;
    logic [23:0] limit, count;
    logic        valid, busy, done;
    logic [1:0]  level_wrap;

    typedef struct {
        string       nm;
        logic        s, c, e, co;
        logic [23:0] lim, cnt;
        logic        val;
        logic [1:0]  w;
        logic        d;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0, n_bad = 0;

    loop_counter #(.WIDTH(12), .LEVELS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .enable(enable),
        .continuous(continuous), .limit(limit), .count(count), .valid(valid),
        .busy(busy), .level_wrap(level_wrap), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int a1, input int a0);
        return {12'(a1), 12'(a0)};
    endfunction

    function automatic vec_t mk(input string nm, input logic s, c, e, co, input logic [23:0] lim,
                                input logic [23:0] cnt, input logic val, input logic [1:0] w, input logic d);
        vec_t v;
        v.nm = nm; v.s = s; v.c = c; v.e = e; v.co = co; v.lim = lim;
        v.cnt = cnt; v.val = val; v.w = w; v.d = d;
        return v;
    endfunction

    task automatic check(input vec_t x);
        n_vec++;
        if (count !== x.cnt || valid !== x.val || busy !== x.val || level_wrap !== x.w || done !== x.d) begin
            n_bad++;
            $display("FAIL %s: got count=%h valid=%b busy=%b wrap=%b done=%b, want count=%h valid=busy=%b wrap=%b done=%b",
                     x.nm, count, valid, busy, level_wrap, done, x.cnt, x.val, x.w, x.d);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        start = v.s; clear = v.c; enable = v.e; continuous = v.co; limit = v.lim;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check(sb.pop_front());
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; clear = 1'b0; enable = 1'b0; continuous = 1'b0; limit = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        tbl.push_back(mk("reset_idle", 0, 0, 1, 0, pk(2, 3), 0, 0, 2'b00, 0));
        // one-shot {2,3}
        tbl.push_back(mk("os_start", 1, 0, 0, 0, pk(2, 3), 0, 1, 2'b00, 0));
        for (int t = 0; t < 12; t++) begin
            if (t < 11)
                tbl.push_back(mk("os_step", 0, 0, 1, 0, pk(9, 9), pk((t + 1) / 4, (t + 1) % 4), 1,
                                 (t % 4 == 3) ? 2'b01 : 2'b00, 0));
            else
                tbl.push_back(mk("os_term", 0, 0, 1, 0, pk(9, 9), pk(2, 3), 0, 2'b11, 1));
        end
        tbl.push_back(mk("os_done_hold", 0, 0, 1, 0, 0, pk(2, 3), 0, 2'b00, 0));
        tbl.push_back(mk("done_start_clear", 1, 1, 1, 0, pk(1, 1), 0, 0, 2'b00, 0));
        tbl.push_back(mk("idle_no_run", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
        // stall then clear at (1,2)
        tbl.push_back(mk("st_start", 1, 0, 1, 0, pk(2, 3), 0, 1, 2'b00, 0));
        tbl.push_back(mk("st_e1", 0, 0, 1, 0, 0, pk(0, 1), 1, 2'b00, 0));
        tbl.push_back(mk("st_e2", 0, 0, 1, 0, 0, pk(0, 2), 1, 2'b00, 0));
        tbl.push_back(mk("st_e3", 0, 0, 1, 0, 0, pk(0, 3), 1, 2'b00, 0));
        tbl.push_back(mk("st_wrap", 0, 0, 1, 0, 0, pk(1, 0), 1, 2'b01, 0));
        tbl.push_back(mk("st_hold1", 0, 0, 0, 0, 0, pk(1, 0), 1, 2'b00, 0));
        tbl.push_back(mk("st_hold2", 0, 0, 0, 0, 0, pk(1, 0), 1, 2'b00, 0));
        tbl.push_back(mk("st_e4", 0, 0, 1, 0, 0, pk(1, 1), 1, 2'b00, 0));
        tbl.push_back(mk("st_e5", 0, 0, 1, 0, 0, pk(1, 2), 1, 2'b00, 0));
        tbl.push_back(mk("clear_run", 0, 1, 1, 0, 0, 0, 0, 2'b00, 0));
        // continuous {1,1}; inputs scrambled mid-run must be ignored
        tbl.push_back(mk("ct_start", 1, 0, 0, 1, pk(1, 1), 0, 1, 2'b00, 0));
        k = 0;
        for (int t = 0; t < 10; t++) begin
            k = (k + 1) % 4;
            tbl.push_back(mk("ct_step", 0, 0, 1, (t < 5), (t < 5) ? pk(1, 1) : pk(0, 0),
                             pk(k / 2, k % 2), 1, {k == 0, k % 2 == 0}, k == 0));
        end
        tbl.push_back(mk("ct_clear", 0, 1, 1, 1, 0, 0, 0, 2'b00, 0));
        // all-zero limits
        tbl.push_back(mk("z_start", 1, 0, 0, 0, 0, 0, 1, 2'b00, 0));
        tbl.push_back(mk("z_term", 0, 0, 1, 0, 0, 0, 0, 2'b11, 1));
        // start during RUN ignored
        tbl.push_back(mk("ig_start", 1, 0, 0, 0, pk(0, 1), 0, 1, 2'b00, 0));
        tbl.push_back(mk("ig_restart", 1, 0, 1, 1, pk(2, 3), pk(0, 1), 1, 2'b00, 0));
        tbl.push_back(mk("ig_term", 0, 0, 1, 0, pk(2, 3), pk(0, 1), 0, 2'b11, 1));
        tbl.push_back(mk("ig_clear", 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // full-range level-0 limit wraps explicitly into level 1
        apply(mk("max_start", 1, 0, 0, 0, pk(1, 4095), 0, 1, 2'b00, 0));
        for (int t = 1; t <= 4095; t++) apply(mk("max_step", 0, 0, 1, 0, 0, pk(0, t), 1, 2'b00, 0));
        apply(mk("max_wrap", 0, 0, 1, 0, 0, pk(1, 0), 1, 2'b01, 0));
        apply(mk("max_clear", 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));

        // asynchronous reset mid-run at (1,2)
        apply(mk("rs_start", 1, 0, 0, 0, pk(2, 3), 0, 1, 2'b00, 0));
        for (int t = 1; t <= 6; t++)
            apply(mk("rs_step", 0, 0, 1, 0, 0, pk(t / 4, t % 4), 1, (t == 4) ? 2'b01 : 2'b00, 0));
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check(mk("rs_async", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
        @(negedge clk);
        rst = 1'b1;
        apply(mk("rs_idle", 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
        apply(mk("rs_restart", 1, 0, 0, 0, pk(2, 3), 0, 1, 2'b00, 0));
        apply(mk("rs_step2", 0, 0, 1, 0, 0, pk(0, 1), 1, 2'b00, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/loop_counter.md
# loop_counter

Parametrised, multi-level nested loop counter that generalises the single-level `counter` block in the decision-tree datapath. It sequences LEVELS cascaded indices, for example pixel column, pixel row and feature index. Each level counts inclusively from 0 to its own runtime limit. The block adds start/clear control, enable-based stall, per-level rollover pulses, one-shot or continuous mode, and a one-cycle done pulse. It feeds feature-address generation and the tree-traversal controller.

## Interface
- WIDTH, 12, bit width of each level's count and limit.
- LEVELS, 2, number of nested levels, legal range 1..4. Level 0 is innermost (fastest).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begins a sequence; honoured in IDLE or DONE only.
- clear  in  1  synchronous abort to IDLE; wins over start.
- enable  in  1  advance; the current tuple is consumed when valid & enable.
- continuous  in  1  mode, sampled on start: 0 = one-shot, 1 = restart after the terminal tuple.
- limit  in  LEVELS*WIDTH  per-level inclusive maximum, level i at [i*WIDTH +: WIDTH]; sampled on start.
- count  out  LEVELS*WIDTH  current index tuple, same packing as limit.
- valid  out  1  count holds a live tuple (state RUN).
- busy  out  1  state RUN.
- level_wrap  out  LEVELS  pulse: level i rolled over (or terminated) on the previous consume.
- done  out  1  one-cycle pulse: the terminal tuple was consumed.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - count = 0, valid = busy = 0.
  - start → RUN; count = 0; limit and continuous latched.
- RUN:
  - valid = busy = 1.
  - On consume, level 0 increments.
  - Level i increments only when all levels < i are at their limits. Otherwise it holds.
  - A level at its limit whose inner levels are all at their limits resets to 0 and sets level_wrap[i] = 1 for one cycle.
- Terminal tuple: every level equals its limit.
- Consuming the terminal tuple:
  - done = 1 for one cycle, and level_wrap is all ones.
  - continuous = 1: count → all zero, stay in RUN.
  - continuous = 0: → DONE.
- DONE:
  - count holds the terminal tuple; valid = busy = 0.
  - start → RUN with new latches; clear → IDLE.
- start while in RUN is ignored.
- clear in any state → IDLE, count = 0, no done or level_wrap pulse. clear is synchronous.
- Arithmetic:
  - Unsigned compare, count == latched limit; a level never exceeds its limit.
  - limit = 0 for a level means that level is always 0 and wraps on every consume of the inner levels.
  - limit = 2^WIDTH-1 is legal; the wrap to 0 is explicit, never a natural overflow.
- Tuples per sequence = Π(limit[i]+1). All-zero limits give exactly one tuple, then done.
- Changing the limit or continuous inputs in RUN has no effect until the next start.

## Timing
- Reset values: state IDLE; count = 0, valid = 0, busy = 0, done = 0, level_wrap = 0. All latched limits = 0 and latched continuous = 0.
- Every output is registered; there is no combinational path from any input to any output.
- start at edge N → valid = 1 and count = 0 after edge N.
- Consume at edge N → the next tuple, level_wrap and done are visible after edge N.
- Throughput: one tuple per cycle with enable held high.
- enable = 0 freezes count, state and latches; done and level_wrap return to 0.
- Reset asserted mid-sequence returns the block to the reset values immediately (asynchronous). The first start after release behaves as from IDLE.

## Structure
- Package `loop_counter_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - Constant MAX_LEVELS = 4.
  - Helper function for the packed slice offset (i*WIDTH).
- Sub-module `count_level`: one level register.
  - Inputs: WIDTH-bit latched limit, carry_in (advance), clear-to-zero.
  - Outputs: count, at_limit, carry_out = carry_in & at_limit.
  - Instantiated LEVELS times by generate. Level 0 carry_in = consume.
- The top level holds the FSM, the limit/continuous latches and the done/level_wrap pulse registers.

## Test plan
- Reset: LEVELS = 2, WIDTH = 12, rst low mid-RUN at count {1,2} → all outputs 0 in the same cycle, state IDLE after release.
- One-shot: limit {L1 = 2, L0 = 3}, continuous = 0, enable held high.
  - 12 tuples in order (0,0) … (2,3).
  - level_wrap[0] pulses after (x,3).
  - done + level_wrap = 2'b11 once after (2,3); then DONE holding (2,3), valid = 0.
- Stall: same limits, enable toggled 1,0,0,1 → count advances only on enable cycles; no pulses during the stall.
- Continuous: limit {1,1}, continuous = 1, 10 enabled cycles → sequence 00,01,10,11 repeats; done every 4th cycle; busy stays 1.
- Boundary: all limits 0 → one tuple, done after the first consume. Level-0 limit 4095 → wraps to 0 with level_wrap[0], no overflow glitch.
- Control collisions:
  - start + clear together in DONE → IDLE.
  - start during RUN with a new limit → ignored; the original sequence completes.
  - clear at tuple (1,2) → IDLE, count 0, no done.
